// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - shared block SRAM port arbiter with independent write/read round-robin
//
// Purpose:
//   Shares one single-write/single-read block SRAM between NUM_PORTS switch
//   ports. Independent round-robin arbiters serve the write (ingress) and read
//   (egress) sides, and each read is tagged so its 1-cycle response is routed
//   back to the requesting port.
//
// Optional feature macro: SRAM_ARB_RAW_BYPASS_EN
//   When defined, a read and write granted in the same cycle to the same
//   address return the new write data (write-before-read).
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   wr_req/wr_addr/wr_data     per-port write request, address, data (sliced per port)
//   wr_gnt                     write grant, one-hot or zero
//   rd_req/rd_addr             per-port read request, address
//   rd_gnt                     read grant, one-hot or zero
//   rd_valid/rd_data           read response strobe (one-hot) and shared data
//   sram_we/sram_w_addr/sram_wdata   SRAM write pins
//   sram_re/sram_r_addr              SRAM read pins
//   sram_rdata/sram_rvalid           SRAM read response
module sram_port_arbiter #(
    parameter int NUM_PORTS  = 4,
    parameter int ADDR_W     = 8,
    parameter int BLOCK_BITS = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_PORTS-1:0]             wr_req,
    input  logic [NUM_PORTS*ADDR_W-1:0]      wr_addr,
    input  logic [NUM_PORTS*BLOCK_BITS-1:0]  wr_data,
    output logic [NUM_PORTS-1:0]             wr_gnt,
    input  logic [NUM_PORTS-1:0]             rd_req,
    input  logic [NUM_PORTS*ADDR_W-1:0]      rd_addr,
    output logic [NUM_PORTS-1:0]             rd_gnt,
    output logic [NUM_PORTS-1:0]             rd_valid,
    output logic [BLOCK_BITS-1:0]            rd_data,
    output logic                             sram_we,
    output logic                             sram_re,
    output logic [ADDR_W-1:0]                sram_w_addr,
    output logic [ADDR_W-1:0]                sram_r_addr,
    output logic [BLOCK_BITS-1:0]            sram_wdata,
    input  logic [BLOCK_BITS-1:0]            sram_rdata,
    input  logic                             sram_rvalid
);

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] rsp_port;
    logic          rsp_pend;

    logic [PW:0]   wr_pick;
    logic [PW:0]   rd_pick;
    logic [PW-1:0] wr_idx;
    logic [PW-1:0] rd_idx;
    logic          wr_any;
    logic          rd_any;

    // Returns {found, index} of the first requester at or after ptr, with wrap.
    // Scanning from the far end lets the nearest hit overwrite earlier ones.
    function automatic logic [PW:0] rr_pick(input logic [NUM_PORTS-1:0] req,
                                            input logic [PW-1:0]        ptr);
        logic [PW:0]   res;
        logic [PW-1:0] pos;
        int            idx;
        res = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_PORTS) begin
                idx = idx - NUM_PORTS;
            end
            pos = idx[PW-1:0];
            if (req[pos]) begin
                res = {1'b1, pos};
            end
        end
        return res;
    endfunction

    function automatic logic [PW-1:0] ptr_after(input logic [PW-1:0] g);
        return (g == PW'(NUM_PORTS - 1)) ? '0 : g + 1'b1;
    endfunction

    assign wr_pick = rr_pick(wr_req, wr_ptr);
    assign rd_pick = rr_pick(rd_req, rd_ptr);
    assign wr_idx  = wr_pick[PW-1:0];
    assign rd_idx  = rd_pick[PW-1:0];

    // Grants are suppressed while reset is held.
    assign wr_any  = wr_pick[PW] && !rst;
    assign rd_any  = rd_pick[PW] && !rst;

    assign wr_gnt  = wr_any ? (NUM_PORTS'(1) << wr_idx) : '0;
    assign rd_gnt  = rd_any ? (NUM_PORTS'(1) << rd_idx) : '0;

    assign sram_we     = wr_any;
    assign sram_re     = rd_any;
    assign sram_w_addr = wr_any ? wr_addr[int'(wr_idx)*ADDR_W +: ADDR_W] : '0;
    assign sram_wdata  = wr_any ? wr_data[int'(wr_idx)*BLOCK_BITS +: BLOCK_BITS] : '0;
    assign sram_r_addr = rd_any ? rd_addr[int'(rd_idx)*ADDR_W +: ADDR_W] : '0;

    // A pending response with no SRAM valid is dropped; reset in the response
    // cycle also discards it.
    assign rd_valid = (rsp_pend && sram_rvalid && !rst) ? (NUM_PORTS'(1) << rsp_port) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rsp_port <= '0;
            rsp_pend <= 1'b0;
        end else begin
            if (wr_any) begin
                wr_ptr <= ptr_after(wr_idx);
            end
            if (rd_any) begin
                rd_ptr   <= ptr_after(rd_idx);
                rsp_port <= rd_idx;
            end
            rsp_pend <= rd_any;
        end
    end

`ifdef SRAM_ARB_RAW_BYPASS_EN
    logic                  byp_hit;
    logic [BLOCK_BITS-1:0] byp_data;

    // The SRAM returns old contents on a same-cycle collision, so remember
    // the colliding write data and substitute it in the response cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            byp_hit  <= 1'b0;
            byp_data <= '0;
        end else begin
            byp_hit  <= rd_any && wr_any && (sram_w_addr == sram_r_addr);
            byp_data <= sram_wdata;
        end
    end

    assign rd_data = byp_hit ? byp_data : sram_rdata;
`else
    assign rd_data = sram_rdata;
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - scoreboard testbench for sram_port_arbiter
module tb_sram_port_arbiter;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int BW = 32;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N-1:0]         wr_req;
    logic [N*AW-1:0]      wr_addr;
    logic [N*BW-1:0]      wr_data;
    logic [N-1:0]         wr_gnt;
    logic [N-1:0]         rd_req;
    logic [N*AW-1:0]      rd_addr;
    logic [N-1:0]         rd_gnt;
    logic [N-1:0]         rd_valid;
    logic [BW-1:0]        rd_data;
    logic                 sram_we;
    logic                 sram_re;
    logic [AW-1:0]        sram_w_addr;
    logic [AW-1:0]        sram_r_addr;
    logic [BW-1:0]        sram_wdata;
    logic [BW-1:0]        sram_rdata = '0;
    logic                 sram_rvalid = 1'b0;

    sram_port_arbiter #(.NUM_PORTS(N), .ADDR_W(AW), .BLOCK_BITS(BW)) dut (
        .clk(clk), .rst(rst),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .sram_we(sram_we), .sram_re(sram_re),
        .sram_w_addr(sram_w_addr), .sram_r_addr(sram_r_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_rvalid(sram_rvalid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural SRAM: write at the edge, read returns pre-write contents.
    logic [BW-1:0] mem [256];
    bit kill_next = 1'b0;
    always @(posedge clk) begin
        if (sram_we) mem[sram_w_addr] <= sram_wdata;
        sram_rdata  <= sram_re ? mem[sram_r_addr] : '0;
        sram_rvalid <= sram_re && !kill_next;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Reference model state
    bit            pw [N];
    bit            pr [N];
    bit            auto_w [N];
    bit            auto_r [N];
    logic [AW-1:0] pwa [N];
    logic [AW-1:0] pra [N];
    logic [BW-1:0] pwd [N];
    logic [BW-1:0] rmem [256];
    int            mwp = 0;
    int            mrp = 0;
    bit            rnd_mode = 1'b0;
    bit            mon_on = 1'b0;

    typedef struct {
        int            due;
        int            port;
        logic [BW-1:0] data;
    } rsp_t;
    rsp_t q[$];

    function automatic int pick(input bit v [N], input int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic cycle(input bit r);
        int            gw;
        int            gr;
        logic [BW-1:0] rdexp;
        rsp_t          e;
        @(posedge clk);
        #1;
        rst = r;
        kill_next = 1'b0;
        if (rnd_mode) begin
            for (int p = 0; p < N; p++) begin
                if (!pw[p] && ($urandom % 3 == 0)) begin
                    pw[p] = 1'b1; pwa[p] = AW'($urandom % 8); pwd[p] = $urandom;
                end
                if (!pr[p] && ($urandom % 3 == 0)) begin
                    pr[p] = 1'b1; pra[p] = AW'($urandom % 8);
                end
            end
        end
        for (int p = 0; p < N; p++) begin
            wr_req[p] = pw[p];
            rd_req[p] = pr[p];
            wr_addr[p*AW +: AW] = pwa[p];
            rd_addr[p*AW +: AW] = pra[p];
            wr_data[p*BW +: BW] = pwd[p];
        end
        #2;
        if (r) begin
            while (q.size() > 0 && q[0].due == cyc) e = q.pop_front();
            mwp = 0; mrp = 0; gw = -1; gr = -1;
        end else begin
            gw = pick(pw, mwp);
            gr = pick(pr, mrp);
        end
        chk("wr_gnt", wr_gnt, (gw >= 0) ? (64'd1 << gw) : 64'd0);
        chk("rd_gnt", rd_gnt, (gr >= 0) ? (64'd1 << gr) : 64'd0);
        chk("sram_we", sram_we, gw >= 0);
        chk("sram_re", sram_re, gr >= 0);
        chk("sram_w_addr", sram_w_addr, (gw >= 0) ? pwa[gw] : '0);
        chk("sram_wdata", sram_wdata, (gw >= 0) ? pwd[gw] : '0);
        chk("sram_r_addr", sram_r_addr, (gr >= 0) ? pra[gr] : '0);
        if (gr >= 0) begin
            rdexp = rmem[pra[gr]];
`ifdef SRAM_ARB_RAW_BYPASS_EN
            if (gw >= 0 && pwa[gw] == pra[gr]) rdexp = pwd[gw];
`endif
            if (rnd_mode && ($urandom % 16 == 0)) kill_next = 1'b1;
            else begin
                e.due = cyc + 1; e.port = gr; e.data = rdexp;
                q.push_back(e);
            end
            mrp = (gr + 1) % N;
            if (!auto_r[gr]) pr[gr] = 1'b0;
        end
        if (gw >= 0) begin
            rmem[pwa[gw]] = pwd[gw];
            mwp = (gw + 1) % N;
            if (auto_w[gw]) pwd[gw] = $urandom;
            else pw[gw] = 1'b0;
        end
    endtask

    // Monitor: pops expected responses when due and compares the DUT output.
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                if (q.size() > 0 && q[0].due == cyc) begin
                    e = q.pop_front();
                    chk("rd_valid", rd_valid, 64'd1 << e.port);
                    chk("rd_data", rd_data, e.data);
                end else begin
                    chk("rd_valid_idle", rd_valid, 64'd0);
                end
            end
        end
    end

    task automatic clear_reqs();
        for (int p = 0; p < N; p++) begin
            pw[p] = 1'b0; pr[p] = 1'b0; auto_w[p] = 1'b0; auto_r[p] = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1;
        wr_req = '0; rd_req = '0; wr_addr = '0; rd_addr = '0; wr_data = '0;
        for (int i = 0; i < 256; i++) begin
            mem[i] = '0; rmem[i] = '0;
        end
        for (int p = 0; p < N; p++) begin
            pwa[p] = '0; pra[p] = '0; pwd[p] = '0;
        end
        clear_reqs();

        // Reset held with all requests up: nothing may be granted
        cycle(1'b1);
        mon_on = 1'b1;
        for (int p = 0; p < N; p++) begin
            pw[p] = 1'b1; pr[p] = 1'b1; pwa[p] = AW'(p); pra[p] = AW'(p); pwd[p] = BW'(p + 100);
        end
        cycle(1'b1);
        cycle(1'b1);
        clear_reqs();
        cycle(1'b0);
        cycle(1'b0);

        // All four ports write continuously: rotation starting at port 0
        for (int p = 0; p < N; p++) begin
            pw[p] = 1'b1; auto_w[p] = 1'b1; pwa[p] = AW'(16 + p); pwd[p] = $urandom;
        end
        for (int i = 0; i < 8; i++) cycle(1'b0);
        clear_reqs();

        // Port 2 writes 0xA5 at 7, then port 0 reads 7
        pw[2] = 1'b1; pwa[2] = 8'd7; pwd[2] = 32'hA5;
        cycle(1'b0);
        pr[0] = 1'b1; pra[0] = 8'd7;
        cycle(1'b0);
        cycle(1'b0);

        // Same-cycle collision at address 5
        pw[0] = 1'b1; pwa[0] = 8'd5; pwd[0] = 32'h11;
        cycle(1'b0);
        pw[1] = 1'b1; pwa[1] = 8'd5; pwd[1] = 32'h3C;
        pr[3] = 1'b1; pra[3] = 8'd5;
        cycle(1'b0);
        cycle(1'b0);

        // Reset in the response cycle, then pointers must restart at 0
        pr[0] = 1'b1; pra[0] = 8'd7;
        cycle(1'b0);
        cycle(1'b1);
        cycle(1'b0);
        for (int p = 0; p < N; p++) begin
            pr[p] = 1'b1; pw[p] = 1'b1; pra[p] = AW'(p); pwa[p] = AW'(32 + p); pwd[p] = $urandom;
        end
        cycle(1'b0);
        clear_reqs();
        cycle(1'b0);

        // Ports 1 and 3 read continuously while port 0 writes every cycle
        pr[1] = 1'b1; auto_r[1] = 1'b1; pra[1] = 8'd7;
        pr[3] = 1'b1; auto_r[3] = 1'b1; pra[3] = 8'd5;
        pw[0] = 1'b1; auto_w[0] = 1'b1; pwa[0] = 8'd40; pwd[0] = $urandom;
        for (int i = 0; i < 8; i++) cycle(1'b0);
        clear_reqs();

        // Randomised traffic with occasional reset and dropped SRAM valid
        rnd_mode = 1'b1;
        for (int i = 0; i < 1500; i++) cycle(($urandom % 200) == 0);
        rnd_mode = 1'b0;
        clear_reqs();
        for (int i = 0; i < 3; i++) cycle(1'b0);

        chk("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Shares the single-write/single-read block SRAM between NUM_PORTS switch ports. Independent round-robin arbiters serve the write side (ingress buffering) and the read side (egress fetch). The block drives the SRAM's we/re/address/data pins, tags each read with the granting port, and routes the 1-cycle read response back to that port. It sits between the per-port ingress/egress engines and the `sram` instance.

## Interface
Parameters:
- NUM_PORTS, 4: number of requesting ports, 2..16.
- ADDR_W, mem_pkg::ADDR_W: block address width.
- BLOCK_BITS, mem_pkg::BLOCK_BITS: block data width.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- wr_req  in  NUM_PORTS  per-port write request.
- wr_addr  in  NUM_PORTS*ADDR_W  per-port write address; port p at slice [p*ADDR_W +: ADDR_W].
- wr_data  in  NUM_PORTS*BLOCK_BITS  per-port write data, sliced the same way.
- wr_gnt  out  NUM_PORTS  write grant, one-hot or zero.
- rd_req  in  NUM_PORTS  per-port read request.
- rd_addr  in  NUM_PORTS*ADDR_W  per-port read address.
- rd_gnt  out  NUM_PORTS  read grant, one-hot or zero.
- rd_valid  out  NUM_PORTS  read response strobe, one-hot or zero.
- rd_data  out  BLOCK_BITS  shared read response data; qualified by rd_valid.
- sram_we, sram_re  out  1  SRAM enables.
- sram_w_addr, sram_r_addr  out  ADDR_W  SRAM addresses.
- sram_wdata  out  BLOCK_BITS  SRAM write data.
- sram_rdata  in  BLOCK_BITS  SRAM read data.
- sram_rvalid  in  1  SRAM read valid.

## Operation
- Handshake: a request is transferred when req[p] && gnt[p] in the same cycle. A requester holds req, addr and data stable until granted. Grant is combinational from req and the pointer registers. Requests may drop without a grant.
- Write arbiter: grants the first requesting port at or after wr_ptr, searching with modulo-NUM_PORTS wrap. On a grant to port g, wr_ptr <= (g+1) mod NUM_PORTS. With no request, wr_ptr holds.
- Read arbiter: identical, using rd_ptr. It is fully independent of the write arbiter, so one write and one read can both be granted in the same cycle.
- SRAM drive: sram_we = |wr_gnt, with the granted port's address and data muxed onto sram_w_addr/sram_wdata. sram_re = |rd_gnt, with the granted address on sram_r_addr. With no grant, address and data outputs drive 0.
- Response tag: on a read grant, register rsp_port <= g and rsp_pend <= 1. In the next cycle, rd_valid[rsp_port] = rsp_pend && sram_rvalid, and rd_data = sram_rdata.
- sram_rvalid low while rsp_pend is set is a protocol error. In that case rd_valid stays 0 and the response is dropped.
- Reset: wr_ptr = 0, rd_ptr = 0, rsp_pend = 0, and registered rd_data = 0. While rst is high, wr_gnt, rd_gnt, sram_we and sram_re are forced to 0.
- Reset mid-operation: if rst is high in the cycle after a read grant, that response is discarded and rd_valid stays 0.

## Timing
- Grant latency is 0 cycles: a request to an idle arbiter whose port is at the pointer is granted in the same cycle.
- Read latency: rd_valid is asserted exactly 1 cycle after rd_gnt.
- Throughput: 1 write plus 1 read per cycle.
- Fairness: under continuous requests from all ports, each port is granted once every NUM_PORTS cycles per side. Maximum wait is NUM_PORTS-1 cycles.
- Back-to-back reads from the same port are allowed, and responses stay in order.

## Configuration
- SRAM_ARB_RAW_BYPASS_EN defined: if the read grant and write grant in the same cycle carry equal addresses, the write data is captured. The next-cycle rd_data then returns that new write data instead of sram_rdata, giving write-before-read semantics.
- Undefined: rd_data always equals sram_rdata, so a same-cycle read of the written address returns the old contents.

## Test plan
- Reset release, no requests -> all gnt, rd_valid, sram_we and sram_re are 0, and both pointers are 0.
- All 4 ports hold wr_req for 8 cycles -> wr_gnt sequence 0001, 0010, 0100, 1000, 0001, …; sram_w_addr tracks the granted port's address.
- Port 2 writes 0xA5 at address 7, then port 0 reads address 7 -> rd_valid = 0001 one cycle after rd_gnt, with rd_data = 0xA5.
- Same cycle, port 1 writes 0x3C at address 5 while port 3 reads address 5 (old contents 0x11) -> rd_data = 0x3C with SRAM_ARB_RAW_BYPASS_EN defined, 0x11 without.
- Read granted, rst asserted the next cycle -> rd_valid stays 0, and after release both pointers are 0.
- Ports 1 and 3 request reads continuously while port 0 writes every cycle -> reads alternate 1, 3, 1, …, writes are granted every cycle, and responses return in grant order.
